// File: rtl/avmm_pio_initiator_if.sv
// Bundles the command/response handshakes and the Avalon-MM PIO bus of avmm_pio_initiator.
// The master modport is the initiator's view; slave is the view of whoever drives commands and models the slave.
interface avmm_pio_initiator_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              chipselect;
   logic              write_n;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, readdata, waitrequest,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, chipselect, write_n, address, writedata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, readdata, waitrequest,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, chipselect, write_n, address, writedata
   );
endinterface

// File: rtl/avmm_pio_initiator.sv
// Single-outstanding Avalon-MM initiator for PIO-style register slaves.
// Define AVMM_PIO_INITIATOR_VERIFY_EN to read back every successful write and check its low 16 bits.
module avmm_pio_initiator #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT      = 255
) (
   input logic                  clk,
   input logic                  reset_n,
   avmm_pio_initiator_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RSP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] LAT_LAST = (READ_LATENCY > 0) ? 16'(READ_LATENCY - 1) : 16'd0;

   state_t            state_reg;
   logic              cmd_ready_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [DATA_W-1:0] rsp_rdata_reg;
   logic              chipselect_reg;
   logic              write_n_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [DATA_W-1:0] writedata_reg;
   // Counts stall cycles in ACCESS and latency cycles in RD_WAIT.
   logic [15:0]       cnt_reg;
   logic              read_err;

`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
   logic verify_reg;
   assign read_err = verify_reg && (bus.readdata[15:0] != writedata_reg[15:0]);
`else
   assign read_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cmd_ready_reg  <= 1'b1;
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
         rsp_rdata_reg  <= '0;
         chipselect_reg <= 1'b0;
         write_n_reg    <= 1'b1;
         address_reg    <= '0;
         writedata_reg  <= '0;
         cnt_reg        <= '0;
`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
         verify_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.cmd_valid) begin
                  address_reg    <= bus.cmd_addr;
                  writedata_reg  <= bus.cmd_wdata;
                  write_n_reg    <= ~bus.cmd_write;
                  chipselect_reg <= 1'b1;
                  cmd_ready_reg  <= 1'b0;
                  cnt_reg        <= '0;
                  state_reg      <= ACCESS;
`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
                  verify_reg     <= 1'b0;
`endif
               end
            end
            ACCESS: begin
               if (!bus.waitrequest) begin
                  if (!write_n_reg) begin
`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
                     // Turn the finished write into a read of the same address; chipselect stays high.
                     write_n_reg    <= 1'b1;
                     verify_reg     <= 1'b1;
                     cnt_reg        <= '0;
`else
                     chipselect_reg <= 1'b0;
                     write_n_reg    <= 1'b1;
                     rsp_rdata_reg  <= '0;
                     rsp_err_reg    <= 1'b0;
                     rsp_valid_reg  <= 1'b1;
                     state_reg      <= RSP;
`endif
                  end else if (READ_LATENCY == 0) begin
                     chipselect_reg <= 1'b0;
                     rsp_rdata_reg  <= bus.readdata;
                     rsp_err_reg    <= read_err;
                     rsp_valid_reg  <= 1'b1;
                     state_reg      <= RSP;
                  end else begin
                     chipselect_reg <= 1'b0;
                     cnt_reg        <= '0;
                     state_reg      <= RD_WAIT;
                  end
               end else if (cnt_reg == TMO_LAST) begin
                  chipselect_reg <= 1'b0;
                  write_n_reg    <= 1'b1;
                  rsp_rdata_reg  <= '0;
                  rsp_err_reg    <= 1'b1;
                  rsp_valid_reg  <= 1'b1;
                  cnt_reg        <= cnt_reg + 16'd1;
                  state_reg      <= RSP;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            RD_WAIT: begin
               if (cnt_reg == LAT_LAST) begin
                  rsp_rdata_reg <= bus.readdata;
                  rsp_err_reg   <= read_err;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RSP;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_rdata  = rsp_rdata_reg;
   assign bus.rsp_err    = rsp_err_reg;
   assign bus.chipselect = chipselect_reg;
   assign bus.write_n    = write_n_reg;
   assign bus.address    = address_reg;
   assign bus.writedata  = writedata_reg;
endmodule

// File: tb/tb_avmm_pio_initiator.sv
// Directed bench for avmm_pio_initiator (TIMEOUT=8, READ_LATENCY=0) with a response scoreboard.
// Also covers the read-back checks when AVMM_PIO_INITIATOR_VERIFY_EN is defined.
module tb_avmm_pio_initiator;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif

   logic clk;
   logic reset_n;
   int   vectors;
   int   miscompares;
   rsp_t exp_q[$];
   int   lat, cs_n, wn_n, unstable;
   logic got;
   logic [1:0]  cur_a;
   logic [31:0] cur_d;

   avmm_pio_initiator_if #(.ADDR_W(2), .DATA_W(32)) bus ();

   avmm_pio_initiator #(
      .ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] a, input logic [31:0] d);
      for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) tick();
      check("cmd_ready_before_issue", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      cur_a = a;
      cur_d = d;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Runs from just after the accept edge until rsp_valid, modelling a slave that stalls `stall` cycles.
   task automatic collect(input string tag, input int stall);
      rsp_t e;
      lat = 0; cs_n = 0; wn_n = 0; unstable = 0; got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.rsp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (bus.chipselect === 1'b1) begin
            bus.waitrequest = (cs_n < stall);
            cs_n++;
            if (bus.write_n === 1'b0) wn_n++;
            if (bus.address !== cur_a || bus.writedata !== cur_d) unstable++;
         end else begin
            bus.waitrequest = 1'b0;
         end
         tick();
         lat++;
      end
      bus.waitrequest = 1'b0;
      check({tag, "_rsp_seen"}, got, 1);
      if (got) begin
         check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
            check({tag, "_err"}, bus.rsp_err, e.err);
         end
         check({tag, "_stable"}, unstable, 0);
      end
   endtask

   task automatic handshake(input string tag);
      bus.rsp_ready = 1'b1;
      tick();
      check({tag, "_hs_valid_low"}, bus.rsp_valid, 0);
      check({tag, "_hs_cmd_ready"}, bus.cmd_ready, 1);
      check({tag, "_hs_cs_low"}, bus.chipselect, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      bus.readdata = '0;
      bus.waitrequest = 1'b0;
      #12;
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_chipselect", bus.chipselect, 0);
      check("rst_write_n", bus.write_n, 1);
      check("rst_address", bus.address, 0);
      check("rst_writedata", bus.writedata, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // Zero-wait write; readdata is junk unless the read-back path consumes it.
      bus.readdata = (VX != 0) ? 32'h0000_0040 : 32'hDEAD_BEEF;
      exp_q.push_back('{rdata: (VX != 0) ? 32'h40 : 32'h0, err: 1'b0});
      issue(1'b1, 2'd0, 32'h0000_0040);
      check("wr0_cs", bus.chipselect, 1);
      check("wr0_write_n", bus.write_n, 0);
      check("wr0_address", bus.address, 0);
      check("wr0_writedata", bus.writedata, 32'h40);
      check("wr0_cmd_ready_low", bus.cmd_ready, 0);
      collect("wr0", 0);
      check("wr0_latency", lat, 1 + VX);
      check("wr0_cs_cycles", cs_n, 1 + VX);
      check("wr0_wn_cycles", wn_n, 1);
      handshake("wr0");

      // Zero-latency read.
      bus.readdata = 32'h0000_000F;
      exp_q.push_back('{rdata: 32'hF, err: 1'b0});
      issue(1'b0, 2'd0, 32'h0);
      check("rd0_cs", bus.chipselect, 1);
      check("rd0_write_n", bus.write_n, 1);
      collect("rd0", 0);
      check("rd0_latency", lat, 1);
      check("rd0_cs_cycles", cs_n, 1);
      check("rd0_wn_cycles", wn_n, 0);
      handshake("rd0");

      // Three waitrequest cycles on a write.
      bus.readdata = 32'h0000_1234;
      exp_q.push_back('{rdata: (VX != 0) ? 32'h1234 : 32'h0, err: 1'b0});
      issue(1'b1, 2'd1, 32'h0000_1234);
      collect("stall", 3);
      check("stall_cs_cycles", cs_n, 4 + VX);
      check("stall_wn_cycles", wn_n, 4);
      check("stall_latency", lat, 4 + VX);
      handshake("stall");

      // Waitrequest stuck high: abort after TIMEOUT cycles.
      bus.readdata = 32'h1111_2222;
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      issue(1'b1, 2'd3, 32'h0000_ABCD);
      collect("tmo", 1000);
      check("tmo_cs_cycles", cs_n, 8);
      check("tmo_wn_cycles", wn_n, 8);
      check("tmo_write_n_restored", bus.write_n, 1);
      handshake("tmo");

      // Response backpressure with an ignored command while the response is pending.
      bus.rsp_ready = 1'b0;
      bus.readdata = 32'h0000_0055;
      exp_q.push_back('{rdata: 32'h55, err: 1'b0});
      issue(1'b0, 2'd2, 32'h0);
      collect("bp", 0);
      bus.readdata = 32'h0000_0077;
      for (int i = 0; i < 5; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b1;
         bus.cmd_addr  = 2'd1;
         bus.cmd_wdata = 32'h0000_0999;
         tick();
         check("bp_hold_valid", bus.rsp_valid, 1);
         check("bp_hold_rdata", bus.rsp_rdata, 32'h55);
         check("bp_cmd_ready_low", bus.cmd_ready, 0);
         check("bp_ignored_cmd_cs", bus.chipselect, 0);
      end
      bus.cmd_valid = 1'b0;
      handshake("bp");
      tick();
      check("bp_no_late_access", bus.chipselect, 0);

      // Reset while chipselect is high: outputs drop without waiting for a clock.
      bus.waitrequest = 1'b1;
      issue(1'b1, 2'd1, 32'h0000_0003);
      tick();
      check("rstmid_cs_before", bus.chipselect, 1);
      #1 reset_n = 1'b0;
      #1;
      check("rstmid_cs", bus.chipselect, 0);
      check("rstmid_rsp_valid", bus.rsp_valid, 0);
      check("rstmid_write_n", bus.write_n, 1);
      check("rstmid_cmd_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1 reset_n = 1'b1;
      bus.waitrequest = 1'b0;
      tick();

      bus.readdata = 32'h0000_00A5;
      exp_q.push_back('{rdata: 32'hA5, err: 1'b0});
      issue(1'b0, 2'd3, 32'h0);
      collect("post_rst", 0);
      handshake("post_rst");

`ifdef AVMM_PIO_INITIATOR_VERIFY_EN
      // Read-back compares only the low 16 bits.
      bus.readdata = 32'h0000_0005;
      exp_q.push_back('{rdata: 32'h5, err: 1'b0});
      issue(1'b1, 2'd2, 32'h0001_0005);
      collect("vfy_ok", 0);
      check("vfy_ok_latency", lat, 2);
      handshake("vfy_ok");

      bus.readdata = 32'h0000_0006;
      exp_q.push_back('{rdata: 32'h6, err: 1'b1});
      issue(1'b1, 2'd2, 32'h0001_0005);
      collect("vfy_bad", 0);
      handshake("vfy_bad");
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/avmm_pio_initiator.md
Name: avmm_pio_initiator

Overview:
- Avalon-MM initiator that drives the PIO-style register slaves on the Nios_CPU_qsys fabric, such as the sample-count output port.
- Accepts single read/write commands on a valid/ready interface and issues one Avalon transaction per command using chipselect/write_n/address/writedata semantics.
- Returns the read data or a write acknowledge on a valid/ready response interface.
- Used by non-CPU logic (e.g. a host command decoder) to program run parameters without Nios involvement.

Parameters:
- ADDR_W, 2, Avalon word-address width.
- DATA_W, 32, Avalon data width.
- READ_LATENCY, 0, cycles after read accept before readdata is sampled (0 = same cycle as accept).
- TIMEOUT, 255, maximum consecutive waitrequest-high cycles before abort; range 1..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  timeout or verify mismatch
- chipselect  out  1  Avalon select
- write_n  out  1  Avalon active-low write
- address  out  ADDR_W  Avalon address
- writedata  out  DATA_W  Avalon write data
- readdata  in  DATA_W  Avalon read data
- waitrequest  in  1  slave stall; tie 0 for zero-wait PIO slaves

Behaviour:
- Reset (async, reset_n=0): state IDLE. cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, chipselect=0, write_n=1, address=0, writedata=0, timeout counter=0.
- Outputs: all Avalon outputs and rsp_* are registered.
- Write/read encoding: write_n=0 only during a write access; a read is chipselect=1 with write_n=1.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/wdata/write and go to ACCESS. From the next cycle: chipselect=1, address/writedata driven, write_n=~cmd_write. cmd_ready=0 in every state except IDLE.
- ACCESS: the access completes in the first cycle with waitrequest=0, so minimum one cycle.
  - Write complete: chipselect=0, write_n=1, go to RSP with rsp_rdata=0 and rsp_err=0.
  - Read complete with READ_LATENCY=0: sample readdata in that cycle, go to RSP.
  - Read complete with READ_LATENCY>0: chipselect=0, go to RD_WAIT.
- RD_WAIT: count READ_LATENCY-1 further cycles, then sample readdata, go to RSP.
- Timeout: the counter increments each ACCESS cycle with waitrequest=1. When it reaches TIMEOUT, drop chipselect, set write_n=1, go to RSP with rsp_err=1 and rsp_rdata=0. The counter clears on entry to ACCESS.
- RSP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. On handshake: rsp_valid=0, go to IDLE, cmd_ready=1 the next cycle.
- Throughput: zero-wait write is command-accept to rsp_valid in 2 cycles; at most one transaction outstanding.
- Simultaneous events: rsp_ready asserted while rsp_valid=0 is ignored. cmd_valid outside IDLE is ignored, and the command is not latched.
- Reset mid-transaction: chipselect drops asynchronously. Any pending response is discarded.
- Address/data are never modified while chipselect=1.

Optional Feature:
- Macro: AVMM_PIO_INITIATOR_VERIFY_EN.
- Defined: after a successful write, the block automatically runs a read of the same address through ACCESS and RD_WAIT, including the timeout rules. It then compares readdata against the written data under a mask of the low 16 bits. On mismatch rsp_err=1; rsp_rdata always returns the read-back value. Write latency grows by 1+READ_LATENCY cycles minimum.
- Not defined: write responds directly as above, with no read-back logic synthesized.

Test Plan:
- Zero-wait write: cmd write addr=0 data=0x0000_0040, waitrequest=0, rsp_ready=1 → one cycle of chipselect=1, write_n=0, address=0, writedata=0x40; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with READ_LATENCY=0: readdata=0x0000_000F, cmd read addr=0 → one chipselect cycle with write_n=1; rsp_rdata=0x0000_000F, rsp_err=0.
- Waitrequest stall: waitrequest=1 for 3 cycles on a write of 0x1234 → chipselect high 4 cycles, address/writedata stable throughout, single response with err=0.
- Timeout with TIMEOUT=8: waitrequest stuck 1 → chipselect drops after 8 cycles; rsp_err=1, rsp_rdata=0; the next command is accepted normally.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid and data held, cmd_ready=0 and a new cmd_valid is ignored; accept resumes the cycle after the handshake.
- Reset mid-access: reset_n=0 while chipselect=1 → chipselect=0 and rsp_valid=0 immediately. With the VERIFY_EN build, a write of 0x0001_0005 with readback 0x0000_0005 gives err=0, while a readback of 0x0006 gives err=1.
